// File: rtl/fetch_buffer_pkg.sv
// Shared types and sizing constants for the fetch buffer between fetch and decode.
package fetch_buffer_pkg;

  localparam int FB_DEFAULT_SIZE = 16;
  localparam int FB_NUM_IN       = 4;
  localparam int FB_NUM_OUT      = 4;
  localparam int FB_BID_W        = 4;

  typedef struct packed {
    logic                valid;
    logic [31:0]         instr;
    logic [31:0]         pc;
    logic                compressed;
    logic [FB_BID_W-1:0] branchID;
    logic                branchPred;
  } IF_Instr;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side and decode-side signals of the fetch buffer.
interface fetch_buffer_if
  import fetch_buffer_pkg::*;
#(
  parameter int NUM_IN  = FB_NUM_IN,
  parameter int NUM_OUT = FB_NUM_OUT
);
  // Handshake: a lane is meaningful only when its valid bit is set. Fetch may
  // present lanes every cycle; they are taken only while OUT_full (registered)
  // is 0, otherwise fetch must hold or replay them. Decode lanes are produced
  // on an edge where IN_frontEn=1 and are held unchanged while IN_frontEn=0.
  logic    IN_frontEn;
  logic    IN_mispredict;
  IF_Instr IN_instr  [NUM_IN];
  logic    OUT_full;
  IF_Instr OUT_instr [NUM_OUT];

  modport master (
    output IN_frontEn, IN_mispredict, IN_instr,
    input  OUT_full, OUT_instr
  );

  modport slave (
    input  IN_frontEn, IN_mispredict, IN_instr,
    output OUT_full, OUT_instr
  );
endinterface

// File: rtl/fb_compact.sv
// Lane compactor: each valid lane's write offset is the number of valid lanes below it.
module fb_compact #(
  parameter  int LANES = 4,
  localparam int CW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] valid_i,
  output logic [CW-1:0]    offset_o [LANES],
  output logic [CW-1:0]    count_o
);

  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < LANES; i++) begin
      offset_o[i] = acc;
      acc         = acc + CW'(valid_i[i]);
    end
    count_o = acc;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Circular instruction queue: compacted multi-lane push from fetch, in-order
// multi-lane pop to decode, mispredict flush and registered full flag.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int NUM_IN   = FB_NUM_IN,
  parameter int NUM_OUT  = FB_NUM_OUT,
  parameter int BUF_SIZE = FB_DEFAULT_SIZE
) (
  input logic           clk,
  input logic           rst_n,
  fetch_buffer_if.slave bus
);

  localparam int AW = $clog2(BUF_SIZE);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(NUM_IN + 1);

  IF_Instr buf_q [BUF_SIZE];
  IF_Instr out_q [NUM_OUT];
  IF_Instr out_d [NUM_OUT];

  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0]     count, count_next, popped, free_next;
  logic              full_q, full_d;
  logic              push_en;
  logic [NUM_IN-1:0] in_valid;
  logic [CW-1:0]     offset [NUM_IN];
  logic [CW-1:0]     in_count;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      in_valid[i] = bus.IN_instr[i].valid;
    end
  end

  fb_compact #(.LANES(NUM_IN)) u_compact (
    .valid_i  (in_valid),
    .offset_o (offset),
    .count_o  (in_count)
  );

  // Full is registered, so a push accepted here always has NUM_IN free slots.
  assign push_en = !full_q && !bus.IN_mispredict;
  assign count   = wptr_q - rptr_q;

  always_comb begin
    popped = '0;
    if (bus.IN_frontEn) begin
      popped = (count < PW'(NUM_OUT)) ? count : PW'(NUM_OUT);
    end
    wptr_d     = wptr_q + (push_en ? PW'(in_count) : '0);
    rptr_d     = rptr_q + popped;
    count_next = wptr_d - rptr_d;
    free_next  = PW'(BUF_SIZE) - count_next;
    full_d     = free_next < PW'(NUM_IN);

    out_d = out_q;
    if (bus.IN_frontEn) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        out_d[i]       = buf_q[rptr_q[AW-1:0] + AW'(i)];
        out_d[i].valid = PW'(i) < popped;
      end
    end

    if (bus.IN_mispredict) begin
      wptr_d = '0;
      rptr_d = '0;
      full_d = 1'b0;
      for (int i = 0; i < NUM_OUT; i++) begin
        out_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      full_q <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      full_q <= full_d;
      out_q  <= out_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_valid[i]) begin
          buf_q[wptr_q[AW-1:0] + AW'(offset[i])] <= bus.IN_instr[i];
        end
      end
    end
  end

  assign bus.OUT_full  = full_q;
  assign bus.OUT_instr = out_q;

  assert property (@(posedge clk) disable iff (!rst_n) count <= PW'(BUF_SIZE));

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: queue-based reference model, directed scenarios and random traffic.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int NUM_IN   = 4;
  localparam int NUM_OUT  = 4;
  localparam int BUF_SIZE = 16;
  localparam int IW       = $bits(IF_Instr);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_buffer_if #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) bus ();

  fetch_buffer #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .BUF_SIZE(BUF_SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: occupancy is the queue size, full follows the free-slot rule.
  logic [IW-1:0] exp_q[$];
  IF_Instr       exp_out [NUM_OUT];
  logic          exp_full;
  IF_Instr       lanes [NUM_IN];
  int            errors = 0;
  int            checks = 0;

  function automatic IF_Instr make_pkt(input logic [31:0] pc);
    IF_Instr p;
    p.valid      = 1'b1;
    p.instr      = $urandom;
    p.pc         = pc;
    p.compressed = 1'($urandom_range(0, 1));
    p.branchID   = FB_BID_W'($urandom_range(0, (1 << FB_BID_W) - 1));
    p.branchPred = 1'($urandom_range(0, 1));
    return p;
  endfunction

  task automatic clear_lanes();
    for (int i = 0; i < NUM_IN; i++) lanes[i] = '0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < NUM_OUT; i++) exp_out[i] = '0;
    exp_full = 1'b0;
  endtask

  task automatic step(input logic fe, input logic mp);
    int n_pre;
    bus.IN_frontEn    = fe;
    bus.IN_mispredict = mp;
    for (int i = 0; i < NUM_IN; i++) bus.IN_instr[i] = lanes[i];
    if (mp) begin
      exp_q.delete();
      for (int i = 0; i < NUM_OUT; i++) exp_out[i].valid = 1'b0;
      exp_full = 1'b0;
    end else begin
      n_pre = exp_q.size();
      if (fe) begin
        for (int i = 0; i < NUM_OUT; i++) begin
          if (i < n_pre) exp_out[i] = IF_Instr'(exp_q.pop_front());
          else exp_out[i] = '0;
        end
      end
      if (!exp_full) begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (lanes[i].valid) exp_q.push_back(IW'(lanes[i]));
        end
      end
      exp_full = (BUF_SIZE - exp_q.size()) < NUM_IN;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.IN_frontEn    = 1'b0;
    bus.IN_mispredict = 1'b0;
    clear_lanes();
    for (int i = 0; i < NUM_IN; i++) bus.IN_instr[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NUM_OUT; i++) begin
      checks++;
      if (bus.OUT_instr[i].valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold lane%0d valid: got %b expected 0", i, bus.OUT_instr[i].valid);
      end
    end
    checks++;
    if (bus.OUT_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold full: got %b expected 0", bus.OUT_full);
    end
    rst_n = 1'b1;
    repeat (5) begin
      step(1'b1, 1'b0);
      for (int i = 0; i < NUM_OUT; i++) begin
        checks++;
        if (bus.OUT_instr[i].valid !== exp_out[i].valid) begin
          errors++;
          $display("FAIL reset_idle lane%0d valid: got %b expected %b", i, bus.OUT_instr[i].valid, exp_out[i].valid);
        end
      end
      checks++;
      if (bus.OUT_full !== exp_full) begin
        errors++;
        $display("FAIL reset_idle full: got %b expected %b", bus.OUT_full, exp_full);
      end
    end
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < NUM_IN; i++) lanes[i] = make_pkt(32'h100 + 32'(4 * i));
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0);
      clear_lanes();
      for (int i = 0; i < NUM_OUT; i++) begin
        checks++;
        if (bus.OUT_instr[i].valid !== exp_out[i].valid ||
            (exp_out[i].valid && bus.OUT_instr[i] !== exp_out[i])) begin
          errors++;
          $display("FAIL push_pop c%0d lane%0d: got %h expected %h", c, i, bus.OUT_instr[i], exp_out[i]);
        end
      end
      if (c == 1) begin
        for (int i = 0; i < NUM_OUT; i++) begin
          checks++;
          if (bus.OUT_instr[i].valid !== 1'b1 || bus.OUT_instr[i].pc !== 32'h100 + 32'(4 * i)) begin
            errors++;
            $display("FAIL push_pop_pc lane%0d: got v=%b pc=%h expected v=1 pc=%h", i,
                     bus.OUT_instr[i].valid, bus.OUT_instr[i].pc, 32'h100 + 32'(4 * i));
          end
        end
      end
    end
  endtask

  task automatic test_compaction();
    logic [31:0] want_pc [2];
    want_pc[0] = 32'h204;
    want_pc[1] = 32'h20C;
    clear_lanes();
    lanes[1] = make_pkt(32'h204);
    lanes[3] = make_pkt(32'h20C);
    step(1'b1, 1'b0);
    clear_lanes();
    step(1'b1, 1'b0);
    for (int i = 0; i < NUM_OUT; i++) begin
      checks++;
      if (bus.OUT_instr[i].valid !== exp_out[i].valid ||
          (exp_out[i].valid && bus.OUT_instr[i] !== exp_out[i])) begin
        errors++;
        $display("FAIL compaction lane%0d: got %h expected %h", i, bus.OUT_instr[i], exp_out[i]);
      end
      checks++;
      if (i < 2) begin
        if (bus.OUT_instr[i].valid !== 1'b1 || bus.OUT_instr[i].pc !== want_pc[i]) begin
          errors++;
          $display("FAIL compaction_pc lane%0d: got v=%b pc=%h expected v=1 pc=%h", i,
                   bus.OUT_instr[i].valid, bus.OUT_instr[i].pc, want_pc[i]);
        end
      end else if (bus.OUT_instr[i].valid !== 1'b0) begin
        errors++;
        $display("FAIL compaction_gap lane%0d valid: got %b expected 0", i, bus.OUT_instr[i].valid);
      end
    end
    step(1'b1, 1'b0);
  endtask

  task automatic test_fill_wrap();
    int  next_seq = 0;
    int  rx       = 0;
    int  total    = 116;
    logic acc;
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < NUM_IN; i++) lanes[i] = make_pkt(32'h1000 + 32'(4 * (next_seq + i)));
      acc = !exp_full;
      step(1'b0, 1'b0);
      if (acc) next_seq += NUM_IN;
      checks++;
      if (bus.OUT_full !== exp_full || bus.OUT_full !== (k >= 4)) begin
        errors++;
        $display("FAIL fill_full push%0d: got %b expected %b", k, bus.OUT_full, (k >= 4));
      end
    end
    for (int cyc = 0; cyc < 300 && rx < total; cyc++) begin
      if (next_seq < total) begin
        for (int i = 0; i < NUM_IN; i++) lanes[i] = make_pkt(32'h1000 + 32'(4 * (next_seq + i)));
      end else begin
        clear_lanes();
      end
      acc = !exp_full && (next_seq < total);
      step(1'b1, 1'b0);
      if (acc) next_seq += NUM_IN;
      for (int i = 0; i < NUM_OUT; i++) begin
        checks++;
        if (bus.OUT_instr[i].valid !== exp_out[i].valid ||
            (exp_out[i].valid && bus.OUT_instr[i] !== exp_out[i])) begin
          errors++;
          $display("FAIL wrap_model lane%0d: got %h expected %h", i, bus.OUT_instr[i], exp_out[i]);
        end
        if (bus.OUT_instr[i].valid === 1'b1) begin
          checks++;
          if (bus.OUT_instr[i].pc !== 32'h1000 + 32'(4 * rx)) begin
            errors++;
            $display("FAIL wrap_order lane%0d pc: got %h expected %h", i, bus.OUT_instr[i].pc, 32'h1000 + 32'(4 * rx));
          end
          rx++;
        end
      end
      checks++;
      if (bus.OUT_full !== exp_full) begin
        errors++;
        $display("FAIL wrap_full: got %b expected %b", bus.OUT_full, exp_full);
      end
    end
    checks++;
    if (rx != total) begin
      errors++;
      $display("FAIL wrap_count: got %0d packets expected %0d", rx, total);
    end
    clear_lanes();
  endtask

  task automatic test_mispredict();
    for (int k = 0; k < 3; k++) begin
      clear_lanes();
      for (int i = 0; i < ((k == 2) ? 2 : NUM_IN); i++) lanes[i] = make_pkt(32'h3000 + 32'(16 * k + 4 * i));
      step(1'b0, 1'b0);
    end
    for (int i = 0; i < NUM_IN; i++) lanes[i] = make_pkt(32'hDEAD0 + 32'(4 * i));
    step(1'b1, 1'b1);
    clear_lanes();
    for (int i = 0; i < NUM_OUT; i++) begin
      checks++;
      if (bus.OUT_instr[i].valid !== 1'b0) begin
        errors++;
        $display("FAIL mispredict_flush lane%0d valid: got %b expected 0", i, bus.OUT_instr[i].valid);
      end
    end
    checks++;
    if (bus.OUT_full !== 1'b0) begin
      errors++;
      $display("FAIL mispredict_full: got %b expected 0", bus.OUT_full);
    end
    repeat (4) begin
      step(1'b1, 1'b0);
      for (int i = 0; i < NUM_OUT; i++) begin
        checks++;
        if (bus.OUT_instr[i].valid !== exp_out[i].valid) begin
          errors++;
          $display("FAIL mispredict_drop lane%0d valid: got %b expected %b pc=%h", i,
                   bus.OUT_instr[i].valid, exp_out[i].valid, bus.OUT_instr[i].pc);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      clear_lanes();
      for (int i = 0; i < ((k == 2) ? 3 : NUM_IN); i++) lanes[i] = make_pkt(32'h5000 + 32'(16 * k + 4 * i));
      step((k == 2), 1'b0);
    end
    clear_lanes();
    for (int i = 0; i < NUM_OUT; i++) begin
      checks++;
      if (bus.OUT_instr[i].valid !== exp_out[i].valid ||
          (exp_out[i].valid && bus.OUT_instr[i] !== exp_out[i])) begin
        errors++;
        $display("FAIL async_pre lane%0d: got %h expected %h", i, bus.OUT_instr[i], exp_out[i]);
      end
    end
    bus.IN_frontEn = 1'b0;
    for (int i = 0; i < NUM_IN; i++) bus.IN_instr[i] = '0;
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NUM_OUT; i++) begin
      checks++;
      if (bus.OUT_instr[i].valid !== 1'b0) begin
        errors++;
        $display("FAIL async_reset lane%0d valid: got %b expected 0", i, bus.OUT_instr[i].valid);
      end
    end
    checks++;
    if (bus.OUT_full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset full: got %b expected 0", bus.OUT_full);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lanes[0] = make_pkt(32'h6000);
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 1'b0);
      clear_lanes();
      for (int i = 0; i < NUM_OUT; i++) begin
        checks++;
        if (bus.OUT_instr[i].valid !== exp_out[i].valid ||
            (exp_out[i].valid && bus.OUT_instr[i] !== exp_out[i])) begin
          errors++;
          $display("FAIL async_after c%0d lane%0d: got %h expected %h", c, i, bus.OUT_instr[i], exp_out[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic fe, mp;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        lanes[i] = make_pkt($urandom);
        lanes[i].valid = ($urandom_range(0, 3) != 0);
      end
      fe = ($urandom_range(0, 3) != 0);
      mp = ($urandom_range(0, 31) == 0);
      step(fe, mp);
      for (int i = 0; i < NUM_OUT; i++) begin
        checks++;
        if (bus.OUT_instr[i].valid !== exp_out[i].valid ||
            (exp_out[i].valid && bus.OUT_instr[i] !== exp_out[i])) begin
          errors++;
          $display("FAIL random c%0d lane%0d: got %h expected %h", c, i, bus.OUT_instr[i], exp_out[i]);
        end
      end
      checks++;
      if (bus.OUT_full !== exp_full) begin
        errors++;
        $display("FAIL random_full c%0d: got %b expected %b", c, bus.OUT_full, exp_full);
      end
    end
    clear_lanes();
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_compaction();
    test_fill_wrap();
    test_mispredict();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
